sw_btn_io_ctrl: RTL and testbench
=================================

# sw_btn_io_ctrl

Parametrised switch/button input controller on the CPU peripheral bus, the successor to the fixed-width switch/button read-back mux. It synchronises and debounces N_SW switches and N_BTN buttons and latches edge events into sticky pending bits. It also raises a maskable interrupt and presents the status word, with LED and counter bits, through a small word-addressed register file.

## Interface
- N_SW, 8, number of switch inputs (1..16)
- N_BTN, 4, number of button inputs (1..8); N_SW+N_BTN+11 ≤ 32
- DB_CYCLES, 16, consecutive stable cycles required to accept a new input level (≥2)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- sw  in  N_SW  raw switch levels, asynchronous to clk
- btn  in  N_BTN  raw button levels, asynchronous to clk, 1 = pressed
- led_out  in  8  current LED register value, read-back only
- counter0_out, counter1_out, counter2_out  in  1 each  counter outputs, read-back only
- cs  in  1  bus select for this device
- we  in  1  write strobe, valid with cs
- addr  in  2  word offset
- cpu_data2bus  in  32  write data
- cpu_data4bus  out  32  read data, combinational from addr and registered state
- irq  out  1  interrupt request, level, active-high

## Operation
- Each raw input passes through a 2-flop synchroniser (reset 0), giving s.
- Per-input debouncer: stable level q (reset 0) and counter c, with c of width clog2(DB_CYCLES).
  - If s == q: c ← 0.
  - If s != q and c == DB_CYCLES-1: q ← s and c ← 0.
  - Otherwise c ← c+1.
- Event vector ev, width N_BTN+N_SW, ordered as {btn, sw}.
  - Button bit: set on a q 0→1 transition (press only).
  - Switch bit: set on any q transition.
  - ev is evaluated from next-q, so it is set on the same edge q flips.
- pend register (N_BTN+N_SW bits): pend ← (pend & ~clr) | ev. Set wins over clear on the same bit in the same cycle.
- mask register (N_BTN+N_SW bits): written directly.
- irq = |(pend & mask).
- Register map: unmapped bits read 0; writes to read-only fields are ignored.
  - addr 0 STATUS (read-only): [31] counter0_out, [30] counter1_out, [29] counter2_out, [N_SW+N_BTN+7:N_SW+N_BTN] led_out, [N_SW+N_BTN-1:N_SW] btn q, [N_SW-1:0] sw q, remaining bits 0.
  - addr 1 PEND: read gives pend in bits [N_BTN+N_SW-1:0]. A write with cs&we gives clr = cpu_data2bus[N_BTN+N_SW-1:0] (write-1-to-clear); clr = 0 otherwise.
  - addr 2 MASK: read/write, bits [N_BTN+N_SW-1:0].
  - addr 3 read returns 0; writes to it are ignored.
- Writes take effect at the clock edge where cs&we is high. There are no wait states.

## Timing
- Reset values: all synchroniser flops, q, c, pend and mask are 0; irq = 0. cpu_data4bus at addr 0 shows only led_out and the counter bits.
- Raw input change to q: the raw input is sampled at edge k. s changes at edge k+1. q flips at edge k+1+DB_CYCLES if the level holds throughout. Any return to the old level resets c.
- pend bit: set at the same edge q flips. irq rises combinationally after that edge if the mask bit is set.
- Read: cpu_data4bus reflects register state in the same cycle as addr; no read side effects.
- W1C: pend clears at the write edge. irq falls after that edge unless ev re-sets the bit on the same edge.
- Async rst asserted mid-debounce or with pending bits set: all state clears immediately. After release, inputs already held high re-debounce from q = 0 and produce fresh events.

## Test plan
- Reset with sw=8'hA5 and btn=4'h0 held:
  - Immediately after rst: STATUS low bits read 0, irq=0.
  - DB_CYCLES+2 cycles after release: STATUS[7:0]=8'hA5 and PEND=12'h0A5.
- Glitch: btn[0] high for DB_CYCLES-1 cycles, then low -> q stays 0 and PEND[8]=0. A held press of DB_CYCLES+2 cycles -> STATUS[8]=1 and PEND[8]=1.
- Button release: btn[0] 1→0 after acceptance -> q goes 0 and PEND[8] is not set again (press-only behaviour).
- Mask/irq: MASK=12'h100 with PEND[8]=1 -> irq=1. MASK=0 -> irq=0. Write PEND=12'h100 -> PEND[8]=0, irq=0.
- Set/clear collision: W1C of bit 9 on the same edge btn[1] is accepted -> PEND[9]=1 after the edge.
- Read-back: led_out=8'h3C, counters=3'b101, addr=0 -> cpu_data4bus[31:29]=3'b101 and [19:12]=8'h3C. addr=3 -> 32'h0. A write to addr 0 changes nothing.

Source files
------------

// File: rtl/sw_btn_io_ctrl.sv
// sw_btn_io_ctrl
//   Switch/button input controller on the CPU peripheral bus. Each raw input is
//   synchronised and debounced. Accepted level changes latch sticky pending bits
//   (switches: either edge; buttons: press only). The pending bits drive a maskable
//   level interrupt. Status, pending and mask are read through a word-addressed
//   register file.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   sw, btn             raw switch / button levels (asynchronous to clk)
//   led_out             LED register value, shown in STATUS
//   counter0..2_out     counter outputs, shown in STATUS
//   cs, we, addr        bus select, write strobe, word offset
//   cpu_data2bus        write data
//   cpu_data4bus        read data (combinational)
//   irq                 interrupt request, |(pend & mask)
//
// Register map
//   0 STATUS (RO)  [31]=counter0 [30]=counter1 [29]=counter2
//                  [NIN+7:NIN]=led_out [NIN-1:0]={btn q, sw q}
//   1 PEND   (W1C) [NIN-1:0]
//   2 MASK   (RW)  [NIN-1:0]
//   3 reads 0, writes ignored
module sw_btn_io_ctrl #(
   parameter int unsigned N_SW      = 8,
   parameter int unsigned N_BTN     = 4,
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SW-1:0]  sw,
   input  logic [N_BTN-1:0] btn,
   input  logic [7:0]       led_out,
   input  logic             counter0_out,
   input  logic             counter1_out,
   input  logic             counter2_out,
   input  logic             cs,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      cpu_data2bus,
   output logic [31:0]      cpu_data4bus,
   output logic             irq
);

   localparam int unsigned NIN = N_SW + N_BTN;
   localparam int unsigned CW  = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

   logic [NIN-1:0] raw;
   logic [NIN-1:0] sync1_q, sync2_q;
   logic [NIN-1:0] q_q, q_d;
   logic [CW-1:0]  cnt_q [NIN];
   logic [CW-1:0]  cnt_d [NIN];
   logic [NIN-1:0] ev;
   logic [NIN-1:0] clr;
   logic [NIN-1:0] pend_q, pend_d;
   logic [NIN-1:0] mask_q, mask_d;
   logic           unused_wdata;

   // Bit order {btn, sw} matches the STATUS/PEND/MASK layouts.
   assign raw = {btn, sw};
   assign unused_wdata = ^cpu_data2bus[31:NIN];

   // Debounce: a new level is taken only after DB_CYCLES consecutive differing samples.
   always_comb begin
      for (int i = 0; i < NIN; i++) begin
         q_d[i]   = q_q[i];
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == q_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntMax) begin
            q_d[i]   = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   // Events come from next-q so pend sets on the same edge q flips.
   always_comb begin
      ev = '0;
      for (int i = 0; i < NIN; i++) begin
         if (i < N_SW) ev[i] = q_d[i] ^ q_q[i];
         else          ev[i] = q_d[i] & ~q_q[i];
      end
   end

   assign clr = (cs && we && addr == 2'd1) ? cpu_data2bus[NIN-1:0] : '0;

   always_comb begin
      pend_d = (pend_q & ~clr) | ev;  // set wins over a same-cycle clear
      mask_d = mask_q;
      if (cs && we && addr == 2'd2) mask_d = cpu_data2bus[NIN-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         q_q     <= '0;
         pend_q  <= '0;
         mask_q  <= '0;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         q_q     <= q_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign irq = |(pend_q & mask_q);

   always_comb begin
      cpu_data4bus = '0;
      unique case (addr)
         2'd0: begin
            cpu_data4bus[31]            = counter0_out;
            cpu_data4bus[30]            = counter1_out;
            cpu_data4bus[29]            = counter2_out;
            cpu_data4bus[NIN+7:NIN]     = led_out;
            cpu_data4bus[NIN-1:0]       = q_q;
         end
         2'd1: cpu_data4bus[NIN-1:0] = pend_q;
         2'd2: cpu_data4bus[NIN-1:0] = mask_q;
         2'd3: cpu_data4bus = '0;
         default: cpu_data4bus = '0;
      endcase
   end

endmodule

// File: tb/tb_sw_btn_io_ctrl.sv
// Directed bench for sw_btn_io_ctrl with the default parameters
// (N_SW=8, N_BTN=4, DB_CYCLES=16). Inputs change 1 ns after a rising edge and
// outputs are sampled later in the same cycle.
module tb_sw_btn_io_ctrl;

   localparam int DB = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  sw;
   logic [3:0]  btn;
   logic [7:0]  led_out;
   logic        counter0_out, counter1_out, counter2_out;
   logic        cs, we;
   logic [1:0]  addr;
   logic [31:0] cpu_data2bus;
   logic [31:0] cpu_data4bus;
   logic        irq;

   int nvec = 0;
   int nerr = 0;
   logic [31:0] rd;

   sw_btn_io_ctrl #(.N_SW(8), .N_BTN(4), .DB_CYCLES(DB)) dut (
      .clk          (clk),
      .rst          (rst),
      .sw           (sw),
      .btn          (btn),
      .led_out      (led_out),
      .counter0_out (counter0_out),
      .counter1_out (counter1_out),
      .counter2_out (counter2_out),
      .cs           (cs),
      .we           (we),
      .addr         (addr),
      .cpu_data2bus (cpu_data2bus),
      .cpu_data4bus (cpu_data4bus),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = cpu_data4bus;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; we = 1'b1; addr = a; cpu_data2bus = d;
      tick();
      cs = 1'b0; we = 1'b0; cpu_data2bus = '0;
   endtask

   initial begin
      rst = 1'b1; sw = 8'hA5; btn = 4'h0; led_out = 8'h00;
      counter0_out = 1'b0; counter1_out = 1'b0; counter2_out = 1'b0;
      cs = 1'b0; we = 1'b0; addr = 2'd0; cpu_data2bus = '0;
      tick(2);

      // Reset state
      bus_rd(2'd0, rd); check("rst_status", rd, 32'h0);
      bus_rd(2'd1, rd); check("rst_pend", rd, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);

      // Switches held high through reset are accepted exactly DB+2 edges after release
      rst = 1'b0;
      tick(DB + 1);
      bus_rd(2'd0, rd); check("sw_not_yet", rd & 32'hFF, 32'h00);
      tick();
      bus_rd(2'd0, rd); check("sw_accept", rd & 32'hFF, 32'hA5);
      bus_rd(2'd1, rd); check("sw_pend", rd, 32'h0A5);

      // Glitch shorter than the debounce window is rejected
      btn[0] = 1'b1; tick(DB - 1);
      btn[0] = 1'b0; tick(6);
      bus_rd(2'd0, rd); check("glitch_q", rd & 32'h100, 32'h0);
      bus_rd(2'd1, rd); check("glitch_pend", rd & 32'h100, 32'h0);

      // Held press is accepted
      btn[0] = 1'b1; tick(DB + 2);
      bus_rd(2'd0, rd); check("press_q", rd & 32'h100, 32'h100);
      bus_rd(2'd1, rd); check("press_pend", rd, 32'h1A5);

      // Mask / irq / W1C
      check("irq_unmasked", {31'b0, irq}, 32'h0);
      bus_wr(2'd2, 32'h100);
      check("irq_masked_on", {31'b0, irq}, 32'h1);
      bus_rd(2'd2, rd); check("mask_rd", rd, 32'h100);
      bus_wr(2'd2, 32'h0);
      check("irq_mask_off", {31'b0, irq}, 32'h0);
      bus_wr(2'd2, 32'h100);
      bus_wr(2'd1, 32'h100);
      bus_rd(2'd1, rd); check("w1c_pend", rd, 32'h0A5);
      check("w1c_irq", {31'b0, irq}, 32'h0);

      // Release does not re-set the button pending bit
      btn[0] = 1'b0; tick(DB + 2);
      bus_rd(2'd0, rd); check("release_q", rd & 32'h100, 32'h0);
      bus_rd(2'd1, rd); check("release_pend", rd, 32'h0A5);

      // Set wins over clear on the same edge
      btn[1] = 1'b1; tick(DB + 1);
      bus_rd(2'd1, rd); check("coll_before", rd & 32'h200, 32'h0);
      bus_wr(2'd1, 32'h200);
      bus_rd(2'd1, rd); check("coll_set_wins", rd & 32'h200, 32'h200);
      bus_wr(2'd1, 32'h200);
      bus_rd(2'd1, rd); check("coll_clear_later", rd & 32'h200, 32'h0);

      // Switch falling edge also produces an event
      bus_wr(2'd1, 32'hFFF);
      sw[0] = 1'b0; tick(DB + 2);
      bus_rd(2'd1, rd); check("sw_fall_pend", rd, 32'h001);

      // Read-back
      led_out = 8'h3C; counter0_out = 1'b1; counter1_out = 1'b0; counter2_out = 1'b1;
      bus_rd(2'd0, rd);
      check("rb_counters", {29'b0, rd[31:29]}, 32'h5);
      check("rb_led", {24'b0, rd[19:12]}, 32'h3C);
      check("rb_status", rd, 32'hA003C2A4);
      bus_rd(2'd3, rd); check("rb_addr3", rd, 32'h0);
      bus_wr(2'd0, 32'hFFFFFFFF);
      bus_rd(2'd0, rd); check("ro_status", rd, 32'hA003C2A4);
      bus_wr(2'd2, 32'hFFFFFABC);
      bus_rd(2'd2, rd); check("mask_rw", rd, 32'hABC);
      bus_wr(2'd3, 32'hFFFFFFFF);
      bus_rd(2'd2, rd); check("addr3_wr_mask", rd, 32'hABC);
      bus_rd(2'd1, rd); check("addr3_wr_pend", rd, 32'h001);
      check("irq_final", {31'b0, irq}, 32'h0);

      // Async reset mid-cycle clears everything, then held inputs re-debounce
      bus_wr(2'd2, 32'hFFF);
      check("irq_pre_rst", {31'b0, irq}, 32'h1);
      #2 rst = 1'b1;
      #1;
      bus_rd(2'd0, rd); check("arst_status", rd, 32'hA003C000);
      bus_rd(2'd1, rd); check("arst_pend", rd, 32'h0);
      bus_rd(2'd2, rd); check("arst_mask", rd, 32'h0);
      check("arst_irq", {31'b0, irq}, 32'h0);
      tick();
      rst = 1'b0;
      tick(DB + 2);
      bus_rd(2'd1, rd); check("rerun_pend", rd, 32'h2A4);
      bus_rd(2'd0, rd); check("rerun_status", rd & 32'hFFF, 32'h2A4);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
